// File: rtl/tictactoe_pkg.sv
// Shared constants for the tic-tac-toe auto player: line table, preference
// order, FSM state encoding and a one-hot helper.
package tictactoe_pkg;

    // Internal "no usable cell on this line" code; never reaches an output.
    localparam logic [3:0] CELL_NONE = 4'hF;

    // Columns, rows, then the two diagonals. Cells are row-major, 0 top-left.
    localparam logic [3:0] LINE_CELLS [8][3] = '{
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Fallback order: centre, corners, then edges.
    localparam logic [3:0] PREF_ORDER [9] = '{
        4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
    };

    typedef enum logic [2:0] {
        ST_IDLE, ST_SCAN_WIN, ST_SCAN_BLOCK, ST_SCAN_PREF,
        ST_DRIVE, ST_RELEASE, ST_WAIT_END, ST_NO_MOVE
    } ap_state_e;

    // One-hot of a cell index; indices above 8 give zero.
    function automatic logic [8:0] cell_onehot(input logic [3:0] idx);
        cell_onehot = (idx <= 4'd8) ? (9'd1 << idx) : 9'd0;
    endfunction

endpackage

// File: rtl/ttt_auto_player_if.sv
// Game-side bus of the auto player: turn/grid status in, move/go out.
interface ttt_auto_player_if;
    logic       enable;
    logic       my_turn;
    logic       game_over;
    logic [8:0] x_grid;
    logic [8:0] o_grid;
    logic [8:0] move;
    logic       go;
    logic [3:0] move_idx;
    logic       busy;
    logic       no_move;

    // master: the auto player, which drives the move stream
    modport master (
        input  enable, my_turn, game_over, x_grid, o_grid,
        output move, go, move_idx, busy, no_move
    );

    // slave: control/datapath side consuming the move stream
    modport slave (
        output enable, my_turn, game_over, x_grid, o_grid,
        input  move, go, move_idx, busy, no_move
    );
endinterface

// File: rtl/ttt_line_eval.sv
// Evaluates one three-cell line: does one side own exactly two cells, and
// which cell (if exactly one) is empty.
module ttt_line_eval
    import tictactoe_pkg::*;
(
    input  logic [3:0] c0,
    input  logic [3:0] c1,
    input  logic [3:0] c2,
    input  logic [8:0] mine,
    input  logic [8:0] theirs,
    output logic       two_mine,
    output logic       two_theirs,
    output logic [3:0] empty_idx
);
    logic [2:0] m, t, e;

    // Gather the three cells and classify the line.
    always_comb begin
        m          = {mine[c2], mine[c1], mine[c0]};
        t          = {theirs[c2], theirs[c1], theirs[c0]};
        e          = ~(m | t);
        two_mine   = ($countones(m) == 2);
        two_theirs = ($countones(t) == 2);
        empty_idx  = CELL_NONE;
        if ($countones(e) == 1)
            empty_idx = e[0] ? c0 : (e[1] ? c1 : c2);
    end
endmodule

// File: rtl/ttt_auto_player.sv
// Computer opponent: scans a frozen grid snapshot for a win, then a block,
// then a preferred empty cell, and emulates a move + go press/release.
// All outputs are registered from the current state, so they trail the
// state register by one cycle.
module ttt_auto_player
    import tictactoe_pkg::*;
#(
    parameter bit SELF_IS_O      = 1'b1,
    parameter int GO_HOLD_CYCLES = 4,
    parameter int RELEASE_CYCLES = 2,
    parameter int CNT_W          = 4
) (
    input  logic              clk,
    input  logic              reset,
    ttt_auto_player_if.master bus
);
    ap_state_e        state, state_n;
    logic [3:0]       idx, idx_n;
    logic [3:0]       sel, sel_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [8:0]       snap_x, snap_o;
    logic             snap_ld;
    logic [8:0]       mine, theirs;
    logic             two_mine, two_theirs;
    logic [3:0]       empty_idx;
    logic [3:0]       pref_cell;
    logic             pref_empty;
    logic             abort;
    logic [CNT_W-1:0] cnt_inc;

    logic [8:0]       move_q;
    logic             go_q, busy_q, no_move_q;
    logic [3:0]       move_idx_q;

    assign mine    = SELF_IS_O ? snap_o : snap_x;
    assign theirs  = SELF_IS_O ? snap_x : snap_o;
    assign abort   = !bus.my_turn || bus.game_over || !bus.enable;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // Single evaluator, steered by the scan index.
    ttt_line_eval u_line (
        .c0        (LINE_CELLS[idx[2:0]][0]),
        .c1        (LINE_CELLS[idx[2:0]][1]),
        .c2        (LINE_CELLS[idx[2:0]][2]),
        .mine      (mine),
        .theirs    (theirs),
        .two_mine  (two_mine),
        .two_theirs(two_theirs),
        .empty_idx (empty_idx)
    );

    // Preference-table entry under the scan index and whether it is free.
    always_comb begin
        pref_cell  = (idx <= 4'd8) ? PREF_ORDER[idx] : CELL_NONE;
        pref_empty = (pref_cell <= 4'd8) && !(snap_x[pref_cell] || snap_o[pref_cell]);
    end

    // State, scan index, chosen cell, counter and snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            sel    <= '0;
            cnt    <= '0;
            snap_x <= '0;
            snap_o <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            if (snap_ld) begin
                snap_x <= bus.x_grid;
                snap_o <= bus.o_grid;
            end
        end
    end

    // Next-state: win scan, block scan, preference scan, then drive/release.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        sel_n   = sel;
        cnt_n   = cnt;
        snap_ld = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.enable && bus.my_turn && !bus.game_over) begin
                    snap_ld = 1'b1;
                    idx_n   = '0;
                    state_n = ST_SCAN_WIN;
                end
            end
            ST_SCAN_WIN, ST_SCAN_BLOCK: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if ((state == ST_SCAN_WIN ? two_mine : two_theirs)
                             && empty_idx != CELL_NONE) begin
                    sel_n   = empty_idx;
                    cnt_n   = '0;
                    state_n = ST_DRIVE;
                end else if (idx == 4'd7) begin
                    idx_n   = '0;
                    state_n = (state == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_SCAN_PREF;
                end else begin
                    idx_n = idx + 4'd1;
                end
            end
            ST_SCAN_PREF: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (pref_empty) begin
                    sel_n   = pref_cell;
                    cnt_n   = '0;
                    state_n = ST_DRIVE;
                end else if (idx == 4'd8) begin
                    state_n = ST_NO_MOVE;
                end else begin
                    idx_n = idx + 4'd1;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (cnt == CNT_W'(GO_HOLD_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_RELEASE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            // Not abortable: the datapath may already have latched the move.
            ST_RELEASE: begin
                if (cnt == CNT_W'(RELEASE_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_WAIT_END;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_WAIT_END: begin
                if (!bus.my_turn)
                    state_n = ST_IDLE;
            end
            ST_NO_MOVE: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Registered outputs derived from the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_q     <= '0;
            go_q       <= 1'b0;
            move_idx_q <= '0;
            busy_q     <= 1'b0;
            no_move_q  <= 1'b0;
        end else begin
            move_q     <= (state == ST_DRIVE || state == ST_RELEASE) ? cell_onehot(sel) : '0;
            move_idx_q <= (state == ST_DRIVE || state == ST_RELEASE) ? sel : '0;
            go_q       <= (state == ST_DRIVE);
            busy_q     <= (state != ST_IDLE);
            no_move_q  <= (state == ST_NO_MOVE);
        end
    end

    assign bus.move     = move_q;
    assign bus.go       = go_q;
    assign bus.move_idx = move_idx_q;
    assign bus.busy     = busy_q;
    assign bus.no_move  = no_move_q;
endmodule

// File: tb/tb_ttt_auto_player.sv
// Directed bench for the auto player: latency/priority cases, no-move,
// abort, async reset and a short closed-loop game.
module tb_ttt_auto_player;
    import tictactoe_pkg::*;

    localparam int NCYC = 34;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ttt_auto_player_if bus();

    ttt_auto_player dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] mv_tr   [1:NCYC];
    logic [3:0] ix_tr   [1:NCYC];
    logic       go_tr   [1:NCYC];
    logic       nm_tr   [1:NCYC];
    logic       busy_tr [1:NCYC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raise my_turn so the next edge is cycle 0, then record cycles 1..NCYC.
    task automatic run_case(input logic [8:0] x, input logic [8:0] o, input int drop_at);
        @(posedge clk); #1;
        bus.x_grid  = x;
        bus.o_grid  = o;
        bus.my_turn = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= NCYC; n++) begin
            @(posedge clk); #1;
            mv_tr[n]   = bus.move;
            ix_tr[n]   = bus.move_idx;
            go_tr[n]   = bus.go;
            nm_tr[n]   = bus.no_move;
            busy_tr[n] = bus.busy;
            if (n == drop_at) bus.my_turn = 1'b0;
        end
        bus.my_turn = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    function automatic int first_go();
        for (int n = 1; n <= NCYC; n++) if (go_tr[n]) return n;
        return -1;
    endfunction

    function automatic int count_go();
        int c = 0;
        for (int n = 1; n <= NCYC; n++) if (go_tr[n]) c++;
        return c;
    endfunction

    function automatic int count_nm();
        int c = 0;
        for (int n = 1; n <= NCYC; n++) if (nm_tr[n]) c++;
        return c;
    endfunction

    // Check a full drive: first go cycle, move/idx, 4-cycle go, 2-cycle release.
    task automatic check_drive(input string tag, input int exp_fg,
                               input logic [8:0] exp_mv, input logic [3:0] exp_ix);
        int fg;
        fg = first_go();
        chk({tag, "_go_cycle"}, fg, exp_fg);
        if (fg > 0 && fg + 6 <= NCYC) begin
            chk({tag, "_move"},      mv_tr[fg], exp_mv);
            chk({tag, "_move_idx"},  ix_tr[fg], exp_ix);
            chk({tag, "_go_len"},    count_go(), 4);
            chk({tag, "_rel_go"},    go_tr[fg+4], 0);
            chk({tag, "_rel_move"},  mv_tr[fg+5], exp_mv);
            chk({tag, "_end_move"},  mv_tr[fg+6], 0);
            chk({tag, "_end_idx"},   ix_tr[fg+6], 0);
        end
    endtask

    // One O turn in the closed loop: wait for go, verify, commit the move.
    task automatic o_turn(input string tag, input logic [8:0] exp_mv);
        logic       got;
        logic [8:0] mv;
        got = 1'b0;
        mv  = '0;
        @(posedge clk); #1;
        bus.my_turn = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (bus.go) begin
                got = 1'b1;
                mv  = bus.move;
                break;
            end
        end
        chk({tag, "_go_seen"}, got, 1);
        chk({tag, "_onehot"}, $countones(mv), 1);
        chk({tag, "_free"}, mv & (bus.x_grid | bus.o_grid), 0);
        chk({tag, "_move"}, mv, exp_mv);
        for (int n = 0; n < 20 && bus.move != 0; n++) begin
            @(posedge clk); #1;
        end
        bus.o_grid  = bus.o_grid | mv;
        bus.my_turn = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        reset         = 1'b0;
        bus.enable    = 1'b1;
        bus.my_turn   = 1'b0;
        bus.game_over = 1'b0;
        bus.x_grid    = '0;
        bus.o_grid    = '0;
        #1;
        chk("rst_move", bus.move, 0);
        chk("rst_go",   bus.go, 0);
        chk("rst_idx",  bus.move_idx, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_nm",   bus.no_move, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Win on line 3 beats block on line 4.
        run_case(9'b000011000, 9'b000000011, 30);
        check_drive("win", 5, 9'b000000100, 4'd2);

        // Block on line 6.
        run_case(9'b000010001, 9'b000000100, 30);
        check_drive("block", 16, 9'b100000000, 4'd8);

        // Empty board -> centre; centre taken -> corner 0.
        run_case(9'b000000000, 9'b000000000, 30);
        check_drive("pref0", 18, 9'b000010000, 4'd4);
        run_case(9'b000010000, 9'b000000000, 30);
        check_drive("pref1", 19, 9'b000000001, 4'd0);

        // Full board without game_over.
        run_case(9'b010101010, 9'b101010101, 26);
        chk("full_nm26",   nm_tr[26], 1);
        chk("full_nm_cnt", count_nm(), 1);
        chk("full_go_cnt", count_go(), 0);
        chk("full_busy26", busy_tr[26], 1);
        chk("full_busy27", busy_tr[27], 0);

        // Abort: my_turn drops in cycle 5.
        run_case(9'b000000000, 9'b000000000, 5);
        chk("abort_busy5", busy_tr[5], 1);
        chk("abort_busy7", busy_tr[7], 0);
        chk("abort_go",    count_go(), 0);
        chk("abort_nm",    count_nm(), 0);

        // Asynchronous reset while go is high.
        @(posedge clk); #1;
        bus.x_grid  = 9'b000011000;
        bus.o_grid  = 9'b000000011;
        bus.my_turn = 1'b1;
        for (int n = 0; n < 40 && !bus.go; n++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_go_seen", bus.go, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_go",   bus.go, 0);
        chk("rst_mid_move", bus.move, 0);
        chk("rst_mid_busy", bus.busy, 0);
        bus.my_turn = 1'b0;
        #20 reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_idle_busy", bus.busy, 0);

        // Closed loop: X at 0; O centre, X at 1; O blocks 2, X at 8; O wins on 6.
        bus.x_grid = 9'b000000001;
        bus.o_grid = 9'b000000000;
        o_turn("loop1", 9'b000010000);
        bus.x_grid = bus.x_grid | 9'b000000010;
        o_turn("loop2", 9'b000000100);
        bus.x_grid = bus.x_grid | 9'b100000000;
        o_turn("loop3", 9'b001000000);
        chk("loop_o_grid", bus.o_grid, 9'b001010100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
